fp_to_fixed: RTL and testbench

- Multi-cycle converter from IEEE-754 single-precision to signed two's-complement fixed point, Q(W-FRAC).(FRAC).
- Sits between the floating-point add/sub datapath and the fixed-point CORDIC iteration core. It undoes the normalisation step: exponent plus hidden-one mantissa become an aligned integer.
- Uses an iterative log shifter, one stage per cycle, with valid/ready handshakes on both sides.

---
 rtl/cordic_fp_pkg.sv | 23 ++
 rtl/fp_unpack.sv | 47 ++++
 rtl/fp_to_fixed.sv | 223 ++++++++++++++++++++++
 tb/tb_fp_to_fixed.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cordic_fp_pkg.sv
// rtl/cordic_fp_pkg.sv - shared IEEE-754 single field widths, class and converter state types

package cordic_fp_pkg;

  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 23;
  localparam int FP_EXP_BIAS = 127;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_t;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    SIGN,
    DONE
  } f2x_state_t;

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - IEEE-754 single field extraction, classification, shift exponent and overflow precompute

module fp_unpack
  import cordic_fp_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 30
) (
  input  logic [31:0]           fp_data,
  output logic                  fp_sign,
  output logic [FP_MAN_W:0]     fp_man,
  output logic signed [9:0]     fp_k,
  output fp_class_t             fp_class,
  output logic                  fp_ovf
);

  // Shift exponent at which the hidden one lands exactly on the output sign bit.
  localparam logic signed [9:0] K_EDGE = 10'(W - 24);
  // Combined bias: unbiased exponent, minus mantissa scaling, plus output fraction.
  localparam logic signed [9:0] K_BIAS = 10'(FRAC - FP_EXP_BIAS - FP_MAN_W);

  logic [FP_EXP_W-1:0] exp_f;
  logic [FP_MAN_W-1:0] man_f;

  // Split fields, classify, and decide overflow from k alone (mantissa only matters on the edge).
  always_comb begin
    fp_sign = fp_data[31];
    exp_f   = fp_data[30:23];
    man_f   = fp_data[22:0];
    fp_man  = {1'b1, man_f};
    fp_k    = $signed({2'b00, exp_f}) + K_BIAS;

    if (exp_f == '0) begin
      fp_class = FP_ZERO;
    end else if (exp_f == '1) begin
      fp_class = (man_f == '0) ? FP_INF : FP_NAN;
    end else begin
      fp_class = FP_NORMAL;
    end

    // On the edge the magnitude is M * 2^(W-24) >= 2^(W-1): only -2^(W-1) exactly still fits.
    fp_ovf = (fp_class == FP_NORMAL) &&
             ((fp_k > K_EDGE) ||
              ((fp_k == K_EDGE) && (!fp_sign || (man_f != '0))));
  end

endmodule

// File: rtl/fp_to_fixed.sv
// rtl/fp_to_fixed.sv - multi-cycle IEEE-754 single to signed fixed point converter (option: FP_TO_FIXED_ROUND_NEAREST_EN)

module fp_to_fixed
  import cordic_fp_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_ovf,
  output logic         out_nan
);

  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
  localparam logic [W:0]   LIM_POS = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0]   LIM_NEG = {2'b01, {(W-1){1'b0}}};
`endif

  // Unpacked view of the incoming word.
  logic                u_sign;
  logic [FP_MAN_W:0]   u_man;
  logic signed [9:0]   u_k;
  fp_class_t           u_class;
  logic                u_ovf;

  fp_unpack #(
    .W    (W),
    .FRAC (FRAC)
  ) u_unpack (
    .fp_data  (in_data),
    .fp_sign  (u_sign),
    .fp_man   (u_man),
    .fp_k     (u_k),
    .fp_class (u_class),
    .fp_ovf   (u_ovf)
  );

  f2x_state_t   state_q, state_d;
  logic [2:0]   stage_q, stage_d;
  logic         sign_q, sign_d;
  fp_class_t    cls_q, cls_d;
  logic         ovf_q, ovf_d;
  logic         shr_q, shr_d;
  logic [4:0]   amt_q, amt_d;
  logic [W-1:0] mag_q, mag_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         out_ovf_q, out_ovf_d;
  logic         out_nan_q, out_nan_d;
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
  logic         guard_q, guard_d;
  logic         sticky_q, sticky_d;
  logic [W:0]   mag_r;
`endif

  logic [9:0]   k_abs;
  logic         flush;
  logic [W-1:0] mag_fin;
  logic         sat_rnd;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_nan   = out_nan_q;

  // Shift amount and direction from k; shifts of 32 or more right always leave zero.
  always_comb begin
    k_abs = u_k[9] ? 10'(-u_k) : 10'(u_k);
    flush = u_k[9] && (k_abs[9:5] != '0);
  end

  // Final rounding of the aligned magnitude, plus the range check a rounding carry can trip.
  always_comb begin
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
    mag_r   = {1'b0, mag_q} + {{W{1'b0}}, (guard_q && (sticky_q || mag_q[0]))};
    sat_rnd = sign_q ? (mag_r > LIM_NEG) : (mag_r > LIM_POS);
    mag_fin = mag_r[W-1:0];
`else
    sat_rnd = 1'b0;
    mag_fin = mag_q;
`endif
  end

  // Next-state and datapath: latch at accept, one log-shifter stage per ALIGN cycle, finish in SIGN.
  always_comb begin
    state_d    = state_q;
    stage_d    = stage_q;
    sign_d     = sign_q;
    cls_d      = cls_q;
    ovf_d      = ovf_q;
    shr_d      = shr_q;
    amt_d      = amt_q;
    mag_d      = mag_q;
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    out_nan_d  = out_nan_q;
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
    guard_d    = guard_q;
    sticky_d   = sticky_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = u_sign;
          cls_d   = u_class;
          ovf_d   = u_ovf;
          shr_d   = u_k[9];
          amt_d   = k_abs[4:0];
          mag_d   = flush ? '0 : W'(u_man);
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
          guard_d  = 1'b0;
          sticky_d = flush;
`endif
          stage_d = 3'd0;
          state_d = ALIGN;
        end
      end

      ALIGN: begin
        for (int i = 0; i < 5; i++) begin
          if ((stage_q == 3'(i)) && amt_q[i]) begin
            if (shr_q) begin
              mag_d = mag_q >> (1 << i);
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
              // Bit just below the new LSB becomes guard; everything below it joins sticky.
              guard_d  = mag_q[(1 << i) - 1];
              sticky_d = sticky_q | guard_q |
                         ((mag_q & ((W'(1) << ((1 << i) - 1)) - W'(1))) != '0);
`endif
            end else begin
              mag_d = mag_q << (1 << i);
            end
          end
        end
        stage_d = stage_q + 3'd1;
        if (stage_q == 3'd4) begin
          state_d = SIGN;
        end
      end

      SIGN: begin
        out_ovf_d = 1'b0;
        out_nan_d = 1'b0;
        unique case (cls_q)
          FP_ZERO: out_data_d = '0;
          FP_NAN: begin
            out_data_d = '0;
            out_nan_d  = 1'b1;
          end
          FP_INF: begin
            out_data_d = sign_q ? SAT_NEG : SAT_POS;
            out_ovf_d  = 1'b1;
          end
          default: begin
            if (ovf_q || sat_rnd) begin
              out_data_d = sign_q ? SAT_NEG : SAT_POS;
              out_ovf_d  = 1'b1;
            end else begin
              out_data_d = sign_q ? (~mag_fin + W'(1)) : mag_fin;
            end
          end
        endcase
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      sign_q     <= 1'b0;
      cls_q      <= FP_ZERO;
      ovf_q      <= 1'b0;
      shr_q      <= 1'b0;
      amt_q      <= '0;
      mag_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
      out_nan_q  <= 1'b0;
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
      guard_q    <= 1'b0;
      sticky_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      sign_q     <= sign_d;
      cls_q      <= cls_d;
      ovf_q      <= ovf_d;
      shr_q      <= shr_d;
      amt_q      <= amt_d;
      mag_q      <= mag_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
      out_nan_q  <= out_nan_d;
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
      guard_q    <= guard_d;
      sticky_q   <= sticky_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_to_fixed.sv
// tb/tb_fp_to_fixed.sv - directed self-checking bench for fp_to_fixed (W=32, FRAC=30)

module tb_fp_to_fixed;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_nan;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_to_fixed #(
    .W    (32),
    .FRAC (30)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_nan   (out_nan)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full conversion with out_ready high: accept, latency, result, handshake.
  task automatic convert(input string tag, input logic [31:0] din, input logic [31:0] exp_data,
                         input logic exp_ovf, input logic exp_nan);
    int n;
    @(negedge clk);
    in_data  = din;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd6);
    check({tag, "_data"}, 64'(out_data), 64'(exp_data));
    check({tag, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
    check({tag, "_nan"}, 64'(out_nan), 64'(exp_nan));
    @(posedge clk);
    #1;
    check({tag, "_vld_low"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_flags", 64'({out_ovf, out_nan}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    convert("one",      32'h3F800000, 32'h40000000, 1'b0, 1'b0);
    convert("neg_half", 32'hBF000000, 32'hE0000000, 1'b0, 1'b0);
    convert("half",     32'h3F000000, 32'h20000000, 1'b0, 1'b0);
    convert("neg_1p5",  32'hBFC00000, 32'hA0000000, 1'b0, 1'b0);
    convert("neg_two",  32'hC0000000, 32'h80000000, 1'b0, 1'b0);
    convert("three",    32'h40400000, 32'h7FFFFFFF, 1'b1, 1'b0);
    convert("big",      32'h7F000000, 32'h7FFFFFFF, 1'b1, 1'b0);
    convert("pinf",     32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0);
    convert("ninf",     32'hFF800000, 32'h80000000, 1'b1, 1'b0);
    convert("nan",      32'h7FC00000, 32'h00000000, 1'b0, 1'b1);
    convert("denorm",   32'h00000001, 32'h00000000, 1'b0, 1'b0);
    convert("min_norm", 32'h00800000, 32'h00000000, 1'b0, 1'b0);
`ifdef FP_TO_FIXED_ROUND_NEAREST_EN
    convert("rnd_075",  32'h30400000, 32'h00000001, 1'b0, 1'b0);
`else
    convert("rnd_075",  32'h30400000, 32'h00000000, 1'b0, 1'b0);
`endif
    convert("rnd_tie",  32'h30000000, 32'h00000000, 1'b0, 1'b0);

    // Backpressure: hold the result for 3 cycles, then release and go back to back.
    out_ready = 1'b0;
    @(negedge clk);
    in_data  = 32'hBF000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold_lat", 64'(n), 64'd6);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("hold_data", 64'(out_data), 64'hE0000000);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    convert("b2b_one", 32'h3F800000, 32'h40000000, 1'b0, 1'b0);

    // Reset during ALIGN stage 2.
    @(negedge clk);
    in_data  = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    convert("post_rst_one", 32'h3F800000, 32'h40000000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
